// File: rtl/mux_pipe_skid.sv
// mux_pipe_skid: N:1 word selector feeding a registered valid/ready stage
// with a single-entry skid register behind the head, so a full stage holds
// two words. in_ready comes straight from a flop and never depends
// combinationally on out_ready.
module mux_pipe_skid #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  // Every select code gets a slot; codes past NUM_IN read as zero, so the
  // selector never indexes outside the array.
  localparam int NUM_SLOT = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

  // Occupancy encoded as {head_valid, skid_valid}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [WIDTH-1:0] chan [NUM_SLOT];
  logic [WIDTH-1:0] word;
  logic             sel_ok;
  logic             accept;
  logic             consume;

  logic [WIDTH-1:0] head_data_reg, head_data_next;
  logic [SEL_W-1:0] head_sel_reg,  head_sel_next;
  logic             head_valid_reg, head_valid_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic [SEL_W-1:0] skid_sel_reg,  skid_sel_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             sel_err_reg,   sel_err_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOT; gi++) begin : g_chan
      if (gi < NUM_IN) begin : g_live
        assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  assign word    = chan[sel];
  assign sel_ok  = ({1'b0, sel} < NUM_IN_EXT);
  assign accept  = in_valid & in_ready;
  assign consume = head_valid_reg & out_ready;

  assign in_ready  = ~skid_valid_reg;
  assign out_valid = head_valid_reg;
  assign out_data  = head_data_reg;
  assign out_sel   = head_sel_reg;
  assign sel_err   = sel_err_reg;

  // Next-state for occupancy and data; flush overrides everything but sel_err.
  always_comb begin
    head_data_next  = head_data_reg;
    head_sel_next   = head_sel_reg;
    head_valid_next = head_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_sel_next   = skid_sel_reg;
    skid_valid_next = skid_valid_reg;
    sel_err_next    = sel_err_reg | (accept & ~sel_ok);

    case ({head_valid_reg, skid_valid_reg})
      ST_EMPTY: begin
        if (accept) begin
          head_valid_next = 1'b1;
          head_data_next  = word;
          head_sel_next   = sel;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          head_data_next = word;
          head_sel_next  = sel;
        end else if (accept) begin
          skid_valid_next = 1'b1;
          skid_data_next  = word;
          skid_sel_next   = sel;
        end else if (consume) begin
          head_valid_next = 1'b0;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path exists.
        if (consume) begin
          head_data_next  = skid_data_reg;
          head_sel_next   = skid_sel_reg;
          skid_valid_next = 1'b0;
        end
      end
      default: begin
        // Skid without head is unreachable; recover to empty.
        head_valid_next = 1'b0;
        skid_valid_next = 1'b0;
      end
    endcase

    if (flush) begin
      head_data_next  = head_data_reg;
      head_sel_next   = head_sel_reg;
      skid_data_next  = skid_data_reg;
      skid_sel_next   = skid_sel_reg;
      head_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_reg  <= '0;
      head_sel_reg   <= '0;
      head_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_sel_reg   <= '0;
      skid_valid_reg <= 1'b0;
      sel_err_reg    <= 1'b0;
    end else begin
      head_data_reg  <= head_data_next;
      head_sel_reg   <= head_sel_next;
      head_valid_reg <= head_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_sel_reg   <= skid_sel_next;
      skid_valid_reg <= skid_valid_next;
      sel_err_reg    <= sel_err_next;
    end
  end

endmodule
